// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: round-robin sharing of one 8-op N-bit ALU between REQ requesters.
// Optional zero flag output rsp_z is enabled by defining ALU_ARB_ZFLAG_EN.
module alu_rr_arbiter #(
  parameter int N   = 4,
  parameter int REQ = 4,
  parameter int IDW = $clog2(REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REQ-1:0]   req,
  input  logic [REQ*N-1:0] op_a,
  input  logic [REQ*N-1:0] op_b,
  input  logic [REQ*3-1:0] op_sel,
  output logic [REQ-1:0]   gnt,
  output logic             busy,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [IDW-1:0]   rsp_id,
  output logic [N-1:0]     rsp_o,
  output logic             rsp_co
`ifdef ALU_ARB_ZFLAG_EN
  ,
  output logic             rsp_z
`endif
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d, win_q, win_d, id_q, id_d;
  logic [N-1:0]   a_q, a_d, b_q, b_d, o_q, o_d;
  logic [2:0]     sel_q, sel_d;
  logic [REQ-1:0] gnt_q, gnt_d;
  logic           vld_q, vld_d, co_q, co_d, z_q, z_d;
  logic           found, take, exec, hold;
  logic [IDW-1:0] pick;
  logic [IDW:0]   idx;
  logic [N:0]     alu_r;

  // first requester at or after ptr, wrapping modulo REQ
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 0; k < REQ; k++) begin
      idx = {1'b0, ptr_q} + (IDW+1)'(k);
      idx = (idx >= (IDW+1)'(REQ)) ? idx - (IDW+1)'(REQ) : idx;
      if (!found && req[idx[IDW-1:0]]) begin
        found = 1'b1;
        pick  = idx[IDW-1:0];
      end
    end
  end

  // shared ALU on the latched operands; bit N is carry/borrow
  always_comb begin
    case (sel_q)
      3'd0:    alu_r = {1'b0, a_q} + {1'b0, b_q};
      3'd1:    alu_r = {1'b0, a_q} - {1'b0, b_q};
      3'd2:    alu_r = {1'b0, a_q} + {{N{1'b0}}, 1'b1};
      3'd3:    alu_r = {1'b0, b_q} - {{N{1'b0}}, 1'b1};
      3'd4:    alu_r = {1'b0, a_q & b_q};
      3'd5:    alu_r = {1'b0, a_q | b_q};
      3'd6:    alu_r = {1'b0, a_q ^ b_q};
      default: alu_r = {1'b0, ~b_q};
    endcase
  end

  // next-state: grant in IDLE, capture result in EXEC, wait for handshake in HOLD
  always_comb begin
    take    = (state_q == IDLE) && found;
    exec    = state_q == EXEC;
    hold    = state_q == HOLD;
    state_d = take ? EXEC : exec ? HOLD : (hold && !rsp_ready) ? HOLD : IDLE;
    ptr_d   = (hold && rsp_ready) ? ((win_q == IDW'(REQ-1)) ? '0 : win_q + 1'b1) : ptr_q;
    win_d   = take ? pick : win_q;
    a_d     = take ? op_a[pick*N +: N] : a_q;
    b_d     = take ? op_b[pick*N +: N] : b_q;
    sel_d   = take ? op_sel[pick*3 +: 3] : sel_q;
    gnt_d   = take ? REQ'(1) << pick : '0;
    vld_d   = exec ? 1'b1 : (hold && rsp_ready) ? 1'b0 : vld_q;
    id_d    = exec ? win_q : id_q;
    o_d     = exec ? alu_r[N-1:0] : o_q;
    co_d    = exec ? alu_r[N] : co_q;
    z_d     = exec ? (alu_r[N-1:0] == '0) : z_q;
  end

  // state registers; reset drops any in-flight transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      vld_q   <= 1'b0;
      id_q    <= '0;
      o_q     <= '0;
      co_q    <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      id_q    <= id_d;
      o_q     <= o_d;
      co_q    <= co_d;
      z_q     <= z_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = state_q != IDLE;
  assign rsp_valid = vld_q;
  assign rsp_id    = id_q;
  assign rsp_o     = o_q;
  assign rsp_co    = co_q;
`ifdef ALU_ARB_ZFLAG_EN
  assign rsp_z     = z_q;
`else
  logic unused_z;
  assign unused_z  = z_q;
`endif
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb_alu_rr_arbiter: directed table, corner sequences and randomized model check.
module tb_alu_rr_arbiter;
  localparam int N   = 4;
  localparam int REQ = 4;
  localparam int IDW = 2;

  typedef struct {
    int id;
    int sel;
    int a;
    int b;
    int o;
    int co;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [REQ-1:0]   req = '0;
  logic [REQ*N-1:0] op_a = '0;
  logic [REQ*N-1:0] op_b = '0;
  logic [REQ*3-1:0] op_sel = '0;
  logic             rsp_ready = 1'b0;
  logic [REQ-1:0]   gnt;
  logic             busy;
  logic             rsp_valid;
  logic [IDW-1:0]   rsp_id;
  logic [N-1:0]     rsp_o;
  logic             rsp_co;
`ifdef ALU_ARB_ZFLAG_EN
  logic             rsp_z;
`endif

  int vectors = 0;
  int miscompares = 0;
  int got_seq[8];
  vec_t tbl[10];

  alu_rr_arbiter #(.N(N), .REQ(REQ)) dut (
    .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b), .op_sel(op_sel),
    .gnt(gnt), .busy(busy), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_o(rsp_o), .rsp_co(rsp_co)
`ifdef ALU_ARB_ZFLAG_EN
    , .rsp_z(rsp_z)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // {co,o} as an (N+1)-bit number straight from the operation definitions
  function automatic int ref_alu(input int sel, input int a, input int b);
    int r;
    case (sel)
      0: r = a + b;
      1: r = a - b;
      2: r = a + 1;
      3: r = b - 1;
      4: r = a & b;
      5: r = a | b;
      6: r = a ^ b;
      default: r = ~b & ((1 << N) - 1);
    endcase
    return r & ((1 << (N + 1)) - 1);
  endfunction

  task automatic load(input int id, input int sel, input int a, input int b);
    op_a[id*N +: N]   = N'(a);
    op_b[id*N +: N]   = N'(b);
    op_sel[id*3 +: 3] = 3'(sel);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, rsp_valid, 0);
    chk({tag, "_id"}, rsp_id, 0);
    chk({tag, "_o"}, rsp_o, 0);
    chk({tag, "_co"}, rsp_co, 0);
`ifdef ALU_ARB_ZFLAG_EN
    chk({tag, "_z"}, rsp_z, 0);
`endif
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req = '0;
    rsp_ready = 1'b0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  // single request from idle: exact grant and response latency
  task automatic run_vec(input vec_t v);
    load(v.id, v.sel, v.a, v.b);
    req = REQ'(1) << v.id;
    rsp_ready = 1'b1;
    tick;
    chk("vec_gnt", gnt, 1 << v.id);
    chk("vec_busy", busy, 1);
    req = '0;
    tick;
    chk("vec_valid", rsp_valid, 1);
    chk("vec_id", rsp_id, v.id);
    chk("vec_o", rsp_o, v.o);
    chk("vec_co", rsp_co, v.co);
`ifdef ALU_ARB_ZFLAG_EN
    chk("vec_z", rsp_z, (v.o == 0) ? 1 : 0);
`endif
    tick;
    chk("vec_done_valid", rsp_valid, 0);
    chk("vec_done_busy", busy, 0);
  endtask

  task automatic order(input logic [REQ-1:0] pat, input int n);
    int cnt;
    int t;
    cnt = 0;
    t = 0;
    for (int i = 0; i < 8; i++) got_seq[i] = -1;
    req = pat;
    rsp_ready = 1'b1;
    while (cnt < n && t < 60) begin
      tick;
      t++;
      if (gnt != 0) begin
        for (int i = 0; i < REQ; i++) if (gnt == (REQ'(1) << i)) got_seq[cnt] = i;
        cnt++;
      end
    end
    req = '0;
    chk("order_grants", cnt, n);
    for (int i = 0; i < 10 && busy; i++) tick;
  endtask

  int exp02[4] = '{0, 2, 0, 2};
  int exp_all[5] = '{0, 1, 2, 3, 0};
  int ph, mp, mw, mres, idx;
  bit ev, hit;
  logic [REQ-1:0] eg;

  initial begin
    tbl[0] = '{0, 0, 9, 8, 1, 1};
    tbl[1] = '{1, 1, 3, 5, 14, 1};
    tbl[2] = '{1, 3, 0, 0, 15, 1};
    tbl[3] = '{1, 7, 0, 5, 10, 0};
    tbl[4] = '{1, 6, 12, 10, 6, 0};
    tbl[5] = '{2, 4, 5, 10, 0, 0};
    tbl[6] = '{3, 2, 15, 0, 0, 1};
    tbl[7] = '{2, 5, 9, 6, 15, 0};
    tbl[8] = '{3, 1, 7, 7, 0, 0};
    tbl[9] = '{0, 3, 4, 9, 8, 0};
    tick;
    chk_zero("reset");
    tick;
    rst = 1'b0;
    // move ptr to 2, then reset mid-cycle while EXEC is in flight
    run_vec(tbl[1]);
    load(0, 0, 9, 8);
    req = '1;
    rsp_ready = 1'b1;
    tick;
    chk("pre_rst_gnt", gnt, 4);
    #3 rst = 1'b1;
    #1 chk_zero("async_rst");
    tick;
    chk_zero("held_rst");
    #4 rst = 1'b0;
    tick;
    chk("post_rst_gnt", gnt, 1);
    chk("post_rst_valid", rsp_valid, 0);
    req = '0;
    tick;
    chk("post_rst_rsp_valid", rsp_valid, 1);
    chk("post_rst_rsp_id", rsp_id, 0);
    chk("post_rst_rsp_o", rsp_o, 1);
    tick;
    chk("post_rst_done", rsp_valid, 0);
    // operation table
    for (int i = 0; i < 10; i++) run_vec(tbl[i]);
    // round-robin order
    do_reset;
    order(4'b0101, 4);
    for (int i = 0; i < 4; i++) chk("order_0_2", got_seq[i], exp02[i]);
    do_reset;
    order(4'b1111, 5);
    for (int i = 0; i < 5; i++) chk("order_all", got_seq[i], exp_all[i]);
    // backpressure in HOLD with req3 pending
    do_reset;
    load(0, 0, 2, 3);
    load(3, 4, 15, 6);
    req = 4'b1001;
    rsp_ready = 1'b0;
    tick;
    chk("bp_gnt0", gnt, 1);
    req = 4'b1000;
    tick;
    chk("bp_valid", rsp_valid, 1);
    chk("bp_o", rsp_o, 5);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_id", rsp_id, 0);
      chk("bp_hold_o", rsp_o, 5);
      chk("bp_hold_co", rsp_co, 0);
      chk("bp_hold_gnt", gnt, 0);
      chk("bp_hold_busy", busy, 1);
    end
    rsp_ready = 1'b1;
    tick;
    chk("bp_hs_valid", rsp_valid, 0);
    chk("bp_hs_gnt", gnt, 0);
    tick;
    chk("bp_gnt3", gnt, 8);
    req = '0;
    tick;
    chk("bp_rsp3_id", rsp_id, 3);
    chk("bp_rsp3_o", rsp_o, 6);
    tick;
    chk("bp_rsp3_done", rsp_valid, 0);
    // randomized traffic against a transaction-level model
    do_reset;
    ph = 0;
    mp = 0;
    mw = 0;
    mres = 0;
    ev = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      req = REQ'($urandom);
      op_a = (REQ*N)'($urandom);
      op_b = (REQ*N)'($urandom);
      op_sel = (REQ*3)'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      eg = '0;
      if (ph == 0) begin
        if (req != 0) begin
          hit = 1'b0;
          for (int k = 0; k < REQ; k++) begin
            idx = (mp + k) % REQ;
            if (!hit && req[idx]) begin
              hit = 1'b1;
              mw = idx;
            end
          end
          mres = ref_alu(int'(op_sel[mw*3 +: 3]), int'(op_a[mw*N +: N]), int'(op_b[mw*N +: N]));
          eg = REQ'(1) << mw;
          ph = 1;
        end
      end else if (ph == 1) begin
        ev = 1'b1;
        ph = 2;
      end else if (rsp_ready) begin
        ev = 1'b0;
        mp = (mw + 1) % REQ;
        ph = 0;
      end
      tick;
      chk("rnd_gnt", gnt, eg);
      chk("rnd_busy", busy, (ph != 0) ? 1 : 0);
      chk("rnd_valid", rsp_valid, ev);
      if (ev) begin
        chk("rnd_id", rsp_id, mw);
        chk("rnd_o", rsp_o, mres & ((1 << N) - 1));
        chk("rnd_co", rsp_co, mres >> N);
`ifdef ALU_ARB_ZFLAG_EN
        chk("rnd_z", rsp_z, ((mres & ((1 << N) - 1)) == 0) ? 1 : 0);
`endif
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
